// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot, sequential fetch, EXE/DEC redirects, load-use holds, stall-time pending redirect.
// Define PC_SEQ_STATS_EN to build the saturating per-source redirect counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR      = 32'h0000_0000,
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        stall_in,
    input  logic        exe_redirect_valid,
    input  logic [31:0] exe_redirect_target,
    input  logic        dec_redirect_valid,
    input  logic [31:0] dec_redirect_target,
    input  logic        load_use,
    output logic [31:0] PC,
    output logic        fetch_valid,
    output logic        flush_if,
    output logic        flush_dec,
    output logic        hold_if,
    output logic [15:0] exe_redirect_count,
    output logic [15:0] dec_redirect_count
);
    typedef enum logic [1:0] {BOOT, RUN, BUBBLE, HOLD} state_t;

    localparam logic [2:0] HOLD_LOAD = 3'(LOAD_STALL_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_fv;
    logic [2:0]  r_cnt;
    logic        r_pend_v;
    logic        r_pend_exe;
    logic [31:0] r_pend_tgt;

    logic        w_pend_exe;
    logic        w_pend_dec;
    logic        w_take_exe;
    logic        w_take_dec;
    logic        w_take_lu;
    logic [31:0] w_tgt;

    assign w_pend_exe = r_pend_v & r_pend_exe;
    assign w_pend_dec = r_pend_v & ~r_pend_exe;

    // A pending redirect outranks a live one of equal or lower priority.
    always_comb begin
        w_take_exe = 1'b0;
        w_take_dec = 1'b0;
        w_take_lu  = 1'b0;
        w_tgt      = exe_redirect_target;
        if (!stall_in) begin
            case (r_state)
                RUN: begin
                    if (w_pend_exe) begin
                        w_take_exe = 1'b1;
                        w_tgt      = r_pend_tgt;
                    end else if (exe_redirect_valid) begin
                        w_take_exe = 1'b1;
                    end else if (w_pend_dec) begin
                        w_take_dec = 1'b1;
                        w_tgt      = r_pend_tgt;
                    end else if (dec_redirect_valid) begin
                        w_take_dec = 1'b1;
                        w_tgt      = dec_redirect_target;
                    end else if (load_use) begin
                        w_take_lu  = 1'b1;
                    end
                end
                BUBBLE, HOLD: begin
                    if (w_pend_exe) begin
                        w_take_exe = 1'b1;
                        w_tgt      = r_pend_tgt;
                    end else if (exe_redirect_valid) begin
                        w_take_exe = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign PC          = r_pc;
    assign fetch_valid = r_fv;
    assign flush_if    = nReset & ~stall_in & (w_take_exe | w_take_dec);
    assign flush_dec   = nReset & ~stall_in & (w_take_exe | (r_state == BUBBLE));
    assign hold_if     = nReset & (stall_in | w_take_lu | ((r_state == HOLD) & ~w_take_exe));

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VECTOR;
            r_fv       <= 1'b0;
            r_cnt      <= 3'd0;
            r_pend_v   <= 1'b0;
            r_pend_exe <= 1'b0;
            r_pend_tgt <= 32'h0;
        end else if (stall_in) begin
            if (exe_redirect_valid) begin
                r_pend_v   <= 1'b1;
                r_pend_exe <= 1'b1;
                r_pend_tgt <= exe_redirect_target;
            end else if (dec_redirect_valid && !w_pend_exe) begin
                r_pend_v   <= 1'b1;
                r_pend_exe <= 1'b0;
                r_pend_tgt <= dec_redirect_target;
            end
        end else begin
            r_fv <= 1'b1;
            // Outside BOOT the pending entry is always consumed: applied, overridden or dropped.
            if (r_state == BOOT) begin
                if (exe_redirect_valid) begin
                    r_pend_v   <= 1'b1;
                    r_pend_exe <= 1'b1;
                    r_pend_tgt <= exe_redirect_target;
                end
            end else begin
                r_pend_v <= 1'b0;
            end
            case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (w_take_exe) begin
                        r_pc    <= w_tgt & ~32'h1;
                        r_state <= BUBBLE;
                    end else if (w_take_dec) begin
                        r_pc    <= w_tgt & ~32'h1;
                    end else if (w_take_lu) begin
                        r_cnt   <= HOLD_LOAD;
                        r_state <= (HOLD_LOAD != 3'd0) ? HOLD : RUN;
                    end else begin
                        r_pc    <= r_pc + 32'd4;
                    end
                end
                BUBBLE: begin
                    if (w_take_exe) begin
                        r_pc    <= w_tgt & ~32'h1;
                    end else begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= RUN;
                    end
                end
                HOLD: begin
                    if (w_take_exe) begin
                        r_pc    <= w_tgt & ~32'h1;
                        r_cnt   <= 3'd0;
                        r_state <= BUBBLE;
                    end else begin
                        r_cnt   <= r_cnt - 3'd1;
                        if (r_cnt == 3'd1) r_state <= RUN;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

`ifdef PC_SEQ_STATS_EN
    logic [15:0] r_exe_cnt;
    logic [15:0] r_dec_cnt;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            r_exe_cnt <= 16'h0;
            r_dec_cnt <= 16'h0;
        end else begin
            if (w_take_exe && r_exe_cnt != 16'hFFFF) r_exe_cnt <= r_exe_cnt + 16'd1;
            if (w_take_dec && r_dec_cnt != 16'hFFFF) r_dec_cnt <= r_dec_cnt + 16'd1;
        end
    end

    assign exe_redirect_count = r_exe_cnt;
    assign dec_redirect_count = r_dec_cnt;
`else
    assign exe_redirect_count = 16'h0000;
    assign dec_redirect_count = 16'h0000;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand sequences, and random traffic
// checked every cycle against a rule-level reference model.
module tb_pc_sequencer;
    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam int          LSC = 3;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        stall_in = 1'b0;
    logic        exe_v = 1'b0, dec_v = 1'b0, lu = 1'b0;
    logic [31:0] exe_t = 32'h0, dec_t = 32'h0;
    logic [31:0] PC;
    logic        fetch_valid, flush_if, flush_dec, hold_if;
    logic [15:0] exe_cnt, dec_cnt;

    pc_sequencer #(.RESET_VECTOR(RV), .LOAD_STALL_CYCLES(LSC)) dut (
        .Clock(Clock), .nReset(nReset), .stall_in(stall_in),
        .exe_redirect_valid(exe_v), .exe_redirect_target(exe_t),
        .dec_redirect_valid(dec_v), .dec_redirect_target(dec_t),
        .load_use(lu), .PC(PC), .fetch_valid(fetch_valid),
        .flush_if(flush_if), .flush_dec(flush_dec), .hold_if(hold_if),
        .exe_redirect_count(exe_cnt), .dec_redirect_count(dec_cnt)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit          chk;
        bit          rst, st, ev;
        logic [31:0] et;
        bit          dv;
        logic [31:0] dt;
        bit          lu;
        logic [31:0] pc;
        bit          fv, fi, fd, ho;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: fetch address, phase flags and a one-slot pending request.
    logic [31:0] m_pc = RV;
    bit          m_fv = 0, m_boot = 1, m_bub = 0;
    int          m_hrem = 0;
    bit          p_v = 0, p_exe = 0;
    logic [31:0] p_t = 32'h0;
    int          m_ce = 0, m_cd = 0;

    function automatic vec_t V(bit rst, bit st, bit ev, logic [31:0] et, bit dv, logic [31:0] dt,
                               bit l, logic [31:0] pc, bit fv, bit fi, bit fd, bit ho);
        vec_t v;
        v.chk = 1; v.rst = rst; v.st = st; v.ev = ev; v.et = et; v.dv = dv; v.dt = dt;
        v.lu = l; v.pc = pc; v.fv = fv; v.fi = fi; v.fd = fd; v.ho = ho;
        return v;
    endfunction

    function automatic vec_t R();
        return V(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input vec_t v, output logic [31:0] epc, output bit efv,
                              output bit efi, output bit efd, output bit eho,
                              output int ece, output int ecd);
        int          src;
        logic [31:0] tgt;
        bit          dec_ok;
        epc = m_pc; efv = m_fv; efi = 0; efd = 0; eho = 0; ece = m_ce; ecd = m_cd;
        src = 0; tgt = 32'h0;
        dec_ok = !m_bub && (m_hrem == 0);
        if (v.rst) begin
            m_pc = RV; m_fv = 0; m_boot = 1; m_bub = 0; m_hrem = 0;
            p_v = 0; p_exe = 0; m_ce = 0; m_cd = 0;
        end else if (v.st) begin
            eho = 1;
            if (v.ev) begin p_v = 1; p_exe = 1; p_t = v.et; end
            else if (v.dv && !(p_v && p_exe)) begin p_v = 1; p_exe = 0; p_t = v.dt; end
        end else if (m_boot) begin
            if (v.ev) begin p_v = 1; p_exe = 1; p_t = v.et; end
            m_boot = 0; m_fv = 1;
        end else begin
            m_fv = 1;
            if (p_v && p_exe)            begin src = 1; tgt = p_t;  end
            else if (v.ev)               begin src = 1; tgt = v.et; end
            else if (dec_ok && p_v)      begin src = 2; tgt = p_t;  end
            else if (dec_ok && v.dv)     begin src = 2; tgt = v.dt; end
            p_v = 0;
            if (src == 1) begin
                efi = 1; efd = 1; m_pc = {tgt[31:1], 1'b0}; m_bub = 1; m_hrem = 0;
`ifdef PC_SEQ_STATS_EN
                if (m_ce < 65535) m_ce++;
`endif
            end else if (src == 2) begin
                efi = 1; m_pc = {tgt[31:1], 1'b0};
`ifdef PC_SEQ_STATS_EN
                if (m_cd < 65535) m_cd++;
`endif
            end else if (m_bub) begin
                efd = 1; m_pc = m_pc + 32'd4; m_bub = 0;
            end else if (m_hrem > 0) begin
                eho = 1; m_hrem--;
            end else if (v.lu) begin
                eho = 1; m_hrem = LSC - 1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [31:0] epc;
        bit          efv, efi, efd, eho;
        int          ece, ecd;
        @(negedge Clock);
        nReset = !v.rst; stall_in = v.st; exe_v = v.ev; exe_t = v.et;
        dec_v = v.dv; dec_t = v.dt; lu = v.lu;
        #1;
        model_step(v, epc, efv, efi, efd, eho, ece, ecd);
        check({tag, " m.flush_if"},  {31'h0, flush_if},  {31'h0, efi});
        check({tag, " m.flush_dec"}, {31'h0, flush_dec}, {31'h0, efd});
        check({tag, " m.hold_if"},   {31'h0, hold_if},   {31'h0, eho});
        if (!v.rst) begin
            check({tag, " m.PC"}, PC, epc);
            check({tag, " m.fetch_valid"}, {31'h0, fetch_valid}, {31'h0, efv});
            check({tag, " m.exe_count"}, {16'h0, exe_cnt}, 32'(ece));
            check({tag, " m.dec_count"}, {16'h0, dec_cnt}, 32'(ecd));
        end
        if (v.chk) begin
            check({tag, " flush_if"},  {31'h0, flush_if},  {31'h0, v.fi});
            check({tag, " flush_dec"}, {31'h0, flush_dec}, {31'h0, v.fd});
            check({tag, " hold_if"},   {31'h0, hold_if},   {31'h0, v.ho});
            if (!v.rst) begin
                check({tag, " PC"}, PC, v.pc);
                check({tag, " fetch_valid"}, {31'h0, fetch_valid}, {31'h0, v.fv});
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        // Columns: rst st ev et dv dt lu | pc fv fi fd ho
        tbl.push_back(R());
        tbl.push_back(R());
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h0,   0,0,0,0));   // BOOT
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h0,   1,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h4,   1,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h8,   1,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 32'hC,   1,0,0,0));
        tbl.push_back(V(0,0,0,0,1,32'h100,0, 32'h10, 1,1,0,0));
        tbl.push_back(V(0,0,1,32'h201,0,0,0, 32'h100, 1,1,1,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h200, 1,0,1,0));   // bubble
        tbl.push_back(V(0,0,0,0,1,32'h40,0, 32'h204, 1,1,0,0));
        tbl.push_back(V(0,0,1,32'h300,1,32'h80,0, 32'h40, 1,1,1,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h300, 1,0,1,0));
        tbl.push_back(V(0,0,0,0,1,32'h20,0, 32'h304, 1,1,0,0));
        tbl.push_back(V(0,0,0,0,0,0,1, 32'h20,  1,0,0,1));   // load-use
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h20,  1,0,0,1));
        tbl.push_back(V(0,0,0,0,1,32'h999,1, 32'h20, 1,0,0,1)); // DEC/load_use ignored in HOLD
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h20,  1,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,1, 32'h24,  1,0,0,1));
        tbl.push_back(V(0,0,1,32'h601,0,0,0, 32'h24, 1,1,1,0)); // abort hold
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h600, 1,0,1,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h604, 1,0,0,0));
        tbl.push_back(V(0,1,0,0,1,32'h500,0, 32'h608, 1,0,0,1)); // stall window
        tbl.push_back(V(0,1,0,0,0,0,0, 32'h608, 1,0,0,1));
        tbl.push_back(V(0,1,1,32'h600,0,0,0, 32'h608, 1,0,0,1));
        tbl.push_back(V(0,1,0,0,0,0,0, 32'h608, 1,0,0,1));
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h608, 1,1,1,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h600, 1,0,1,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h604, 1,0,0,0));
        tbl.push_back(V(0,0,0,0,1,32'hFFFF_FFFD,0, 32'h608, 1,1,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 32'hFFFF_FFFC, 1,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h0,   1,0,0,0));   // wrap
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h4,   1,0,0,0));
        tbl.push_back(V(0,1,0,0,0,0,1, 32'h8,   1,0,0,1));   // load_use under stall dropped
        tbl.push_back(V(0,0,0,0,0,0,0, 32'h8,   1,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 32'hC,   1,0,0,0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Reset with a pending EXE in flight: nothing may be applied afterwards.
        apply(V(0,1,1,32'h700,0,0,0, 32'h10, 1,0,0,1), "rstA0");
        apply(R(), "rstA1");
        apply(R(), "rstA2");
        apply(V(0,0,0,0,0,0,0, 32'h0, 0,0,0,0), "rstA3");
        apply(V(0,0,0,0,0,0,0, 32'h0, 1,0,0,0), "rstA4");
        apply(V(0,0,0,0,0,0,0, 32'h4, 1,0,0,0), "rstA5");

        // EXE redirect during BOOT is applied on the first RUN cycle.
        apply(R(), "bootB0");
        apply(V(0,0,1,32'h1000,0,0,0, 32'h0, 0,0,0,0), "bootB1");
        apply(V(0,0,0,0,0,0,0, 32'h0,    1,1,1,0), "bootB2");
        apply(V(0,0,0,0,0,0,0, 32'h1000, 1,0,1,0), "bootB3");
        apply(V(0,0,0,0,0,0,0, 32'h1004, 1,0,0,0), "bootB4");

        // Live EXE on release overrides a pending DEC.
        apply(V(0,1,0,0,1,32'h800,0, 32'h1008, 1,0,0,1), "ovrC0");
        apply(V(0,0,1,32'h900,0,0,0, 32'h1008, 1,1,1,0), "ovrC1");
        apply(V(0,0,0,0,0,0,0, 32'h900, 1,0,1,0), "ovrC2");
        apply(V(0,0,0,0,0,0,0, 32'h904, 1,0,0,0), "ovrC3");

        for (int i = 0; i < 3000; i++) begin
            vec_t v;
            v = V(0,0,0,0,0,0,0, 0,0,0,0,0);
            v.chk = 0;
            v.rst = ($urandom_range(0, 199) == 0);
            v.st  = ($urandom_range(0, 3) == 0);
            v.ev  = ($urandom_range(0, 9) == 0);
            v.dv  = ($urandom_range(0, 6) == 0);
            v.lu  = ($urandom_range(0, 7) == 0);
            v.et  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            v.dt  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            apply(v, "rnd");
        end

`ifdef PC_SEQ_STATS_EN
        apply(R(), "sat0");
        for (int i = 0; i < 65540; i++) begin
            vec_t v;
            v = V(0,0,0,0,1,$urandom,0, 0,0,0,0,0);
            v.chk = 0;
            apply(v, "sat");
        end
        @(negedge Clock);
        check("dec_count_saturated", {16'h0, dec_cnt}, 32'h0000_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC loaded at reset.
REQ-002 SHALL have parameter LOAD_STALL_CYCLES, default 1, range 1..7: PC hold length per load-use hazard.
REQ-003 SHALL provide ports, clock and reset first:
- Clock  in  1  sole clock, all state on posedge.
- nReset  in  1  reset, synchronous, active-low.
- stall_in  in  1  external freeze (e.g. memory wait).
- exe_redirect_valid  in  1  EXE-stage mispredict/JALR redirect request.
- exe_redirect_target  in  32  EXE redirect address.
- dec_redirect_valid  in  1  DEC-stage JAL/predicted-taken redirect request.
- dec_redirect_target  in  32  DEC redirect address.
- load_use  in  1  load-use hazard, pulse.
- PC  out  32  current fetch address.
- fetch_valid  out  1  PC is a real fetch this cycle.
- flush_if  out  1  kill IF-stage instruction.
- flush_dec  out  1  kill DEC-stage instruction.
- hold_if  out  1  IF/DEC registers hold.
- exe_redirect_count  out  16  EXE redirects applied.
- dec_redirect_count  out  16  DEC redirects applied.

Function
REQ-004 SHALL implement FSM states BOOT, RUN, BUBBLE, HOLD.
REQ-005 BOOT: fetch_valid=0, PC=RESET_VECTOR; next cycle RUN.
REQ-006 RUN, no event: PC <= PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0); fetch_valid=1.
REQ-007 Event priority per cycle: EXE redirect > DEC redirect > load_use > sequential.
REQ-008 Accepted EXE redirect: PC <= {target[31:1],1'b0}; flush_if=1 and flush_dec=1 combinationally same cycle; next state BUBBLE.
REQ-009 BUBBLE: fetch_valid=1, flush_dec=1 for exactly one cycle; then RUN; a new EXE redirect in BUBBLE is accepted per REQ-008.
REQ-010 Accepted DEC redirect: PC <= {target[31:1],1'b0}; flush_if=1 same cycle; state stays RUN; no bubble.
REQ-011 load_use in RUN: PC unchanged, hold_if=1, down-counter loaded with LOAD_STALL_CYCLES-1, state HOLD if count>0 else remain RUN after the single hold cycle.
REQ-012 HOLD: PC unchanged, hold_if=1, counter decrements; RUN when counter reaches 0; EXE redirect in HOLD aborts hold and applies REQ-008; DEC redirect and load_use ignored in HOLD.
REQ-013 stall_in=1: PC, state, counter frozen; flush_*=0, hold_if=1, fetch_valid unchanged.
REQ-014 Redirect arriving during stall SHALL be captured in a one-entry pending buffer (valid, source, target); EXE overwrites pending DEC or older EXE; DEC dropped when pending EXE present; DEC overwrites older DEC.
REQ-015 On the first cycle with stall_in=0, pending entry SHALL be applied as if accepted that cycle, ahead of any same-cycle live request of equal or lower priority; live EXE request same cycle overrides pending DEC.
REQ-016 Pending buffer cleared when applied or overridden.
REQ-017 load_use during stall SHALL be dropped (hazard persists in DEC and is re-asserted by decoder).
REQ-018 EXE redirect in BOOT SHALL be held pending and applied on entry to RUN.
REQ-019 flush_if, flush_dec, hold_if SHALL be zero in any cycle with no event listed above.

Reset
REQ-020 nReset=0 sampled on a posedge: state BOOT, PC=RESET_VECTOR, fetch_valid=0, flush_if=0, flush_dec=0, hold_if=0, counter=0, pending cleared, both counts 0.
REQ-021 Reset mid-operation (HOLD, BUBBLE, stall, pending) SHALL discard all in-flight state with no redirect applied.

Configuration
REQ-022 Macro PC_SEQ_STATS_EN defined: exe_redirect_count and dec_redirect_count increment by 1 per applied redirect of their source, saturating at 16'hFFFF.
REQ-023 Macro PC_SEQ_STATS_EN undefined: counter logic absent, both count ports tied to 16'h0000; all other behaviour identical.

Verification
REQ-024 Reset release, RUN 3 cycles -> PC 0x0, then 0x4, 0x8, 0xC after BOOT cycle; fetch_valid=0 in BOOT only.
REQ-025 PC=0x100, exe_redirect 0x201 -> same cycle flush_if=flush_dec=1; next PC 0x200; next cycle flush_dec=1 (BUBBLE); then PC 0x204.
REQ-026 PC=0x40, dec_redirect 0x80 and exe_redirect 0x300 same cycle -> PC 0x300, dec dropped, exe_redirect_count=1 with stats enabled.
REQ-027 LOAD_STALL_CYCLES=3, load_use at PC=0x20 -> hold_if=1 for 3 cycles, PC 0x20 throughout, then 0x24; exe redirect in 2nd hold cycle aborts to target.
REQ-028 stall_in high 4 cycles, dec_redirect 0x500 in cycle 1, exe_redirect 0x600 in cycle 3 -> PC frozen; after release PC 0x600, flush_if=flush_dec=1; 0x500 never fetched.
REQ-029 PC=0xFFFF_FFFC, RUN -> next PC 0x0000_0000; stats build with 65536 DEC redirects -> dec_redirect_count stays 16'hFFFF.
